// File: rtl/accelerator_integration_pkg.sv
// Shared state encodings and constants for the tensor integration accelerator.
package accelerator_integration_pkg;

  typedef logic [1:0] state_t;

  localparam state_t STARTER_STATE = 2'd0;
  localparam state_t INPUT_STATE   = 2'd1;
  localparam state_t ENDER_STATE   = 2'd2;

  localparam int DEFAULT_DATA_SIZE    = 64;
  localparam int DEFAULT_CONTROL_SIZE = 64;

  localparam logic [DEFAULT_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
  localparam logic [DEFAULT_CONTROL_SIZE-1:0] ONE_CONTROL  = {{(DEFAULT_CONTROL_SIZE-1){1'b0}}, 1'b1};
  localparam logic [DEFAULT_DATA_SIZE-1:0]    ZERO_DATA    = '0;
  localparam logic [DEFAULT_DATA_SIZE-1:0]    ONE_DATA     = {{(DEFAULT_DATA_SIZE-1){1'b0}}, 1'b1};

endpackage

// File: rtl/accelerator_tensor_integration_if.sv
// Stream/control bundle between a tensor producer and the integration accelerator.
interface accelerator_tensor_integration_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic                 DATA_IN_ENABLE;
  logic                 DATA_OUT_K_ENABLE;
  logic                 DATA_OUT_J_ENABLE;
  logic                 DATA_OUT_I_ENABLE;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] SIZE_K_IN;
  logic [DATA_SIZE-1:0] PERIOD_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic [DATA_SIZE-1:0] DATA_OUT;

  modport master (
    output START, DATA_IN_ENABLE, SIZE_I_IN, SIZE_J_IN, SIZE_K_IN, PERIOD_IN, DATA_IN,
    input  READY, DATA_OUT_K_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_I_ENABLE, DATA_OUT
  );

  modport slave (
    input  START, DATA_IN_ENABLE, SIZE_I_IN, SIZE_J_IN, SIZE_K_IN, PERIOD_IN, DATA_IN,
    output READY, DATA_OUT_K_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_I_ENABLE, DATA_OUT
  );
endinterface

// File: rtl/accelerator_tensor_index_counter.sv
// Nested i/j/k element counters (k fastest) with end-of-line/slice/tensor flags.
module accelerator_tensor_index_counter #(
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic [CONTROL_SIZE-1:0] size_i,
  input  logic [CONTROL_SIZE-1:0] size_j,
  input  logic [CONTROL_SIZE-1:0] size_k,
  output logic                    first_k,
  output logic                    last_k,
  output logic                    last_j,
  output logic                    last_all
);
  logic [CONTROL_SIZE-1:0] size_i_r, size_j_r, size_k_r;
  logic [CONTROL_SIZE-1:0] i_q, j_q, k_q;
  logic                    last_i;

  localparam logic [CONTROL_SIZE-1:0] ONE = CONTROL_SIZE'(1);

  // last_j/last_all are cumulative: they imply every faster index is also at max
  assign first_k  = (k_q == '0);
  assign last_k   = (k_q == size_k_r - ONE);
  assign last_j   = last_k && (j_q == size_j_r - ONE);
  assign last_i   = (i_q == size_i_r - ONE);
  assign last_all = last_j && last_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      size_i_r <= '0;
      size_j_r <= '0;
      size_k_r <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else if (load) begin
      size_i_r <= size_i;
      size_j_r <= size_j;
      size_k_r <= size_k;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else if (advance) begin
      if (last_k) begin
        k_q <= '0;
        if (last_j) begin
          j_q <= '0;
          i_q <= last_i ? '0 : i_q + ONE;
        end else begin
          j_q <= j_q + ONE;
        end
      end else begin
        k_q <= k_q + ONE;
      end
    end
  end
endmodule

// File: rtl/accelerator_tensor_integration.sv
// Streaming rectangle-rule integrator along k for rank-3 tensors:
// y[i][j][k] = PERIOD * sum(x[i][j][0..k]), one registered result per input beat.
module accelerator_tensor_integration
  import accelerator_integration_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input logic CLK,
  input logic RST,
  accelerator_tensor_integration_if.slave bus
);
  state_t               state;
  logic [DATA_SIZE-1:0] period_r;
  logic [DATA_SIZE-1:0] acc;
  logic [DATA_SIZE-1:0] data_out_r;
  logic                 k_en_r, j_en_r, i_en_r, ready_r;

  logic                 load, advance, any_zero;
  logic                 first_k, last_k, last_j, last_all;
  logic [DATA_SIZE-1:0] product, acc_next;

  assign load     = (state == STARTER_STATE) && bus.START;
  assign advance  = (state == INPUT_STATE) && bus.DATA_IN_ENABLE;
  assign any_zero = (bus.SIZE_I_IN == '0) || (bus.SIZE_J_IN == '0) || (bus.SIZE_K_IN == '0);

  // Low DATA_SIZE bits of the product are the same for signed and unsigned operands
  assign product  = bus.DATA_IN * period_r;
  assign acc_next = (first_k ? '0 : acc) + product;

  accelerator_tensor_index_counter #(.CONTROL_SIZE(CONTROL_SIZE)) u_idx (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .advance  (advance),
    .size_i   (CONTROL_SIZE'(bus.SIZE_I_IN)),
    .size_j   (CONTROL_SIZE'(bus.SIZE_J_IN)),
    .size_k   (CONTROL_SIZE'(bus.SIZE_K_IN)),
    .first_k  (first_k),
    .last_k   (last_k),
    .last_j   (last_j),
    .last_all (last_all)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= STARTER_STATE;
      period_r   <= '0;
      acc        <= '0;
      data_out_r <= '0;
      k_en_r     <= 1'b0;
      j_en_r     <= 1'b0;
      i_en_r     <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      k_en_r  <= 1'b0;
      j_en_r  <= 1'b0;
      i_en_r  <= 1'b0;
      ready_r <= 1'b0;
      case (state)
        STARTER_STATE: begin
          if (bus.START) begin
            period_r <= bus.PERIOD_IN;
            acc      <= '0;
            state    <= any_zero ? ENDER_STATE : INPUT_STATE;
          end
        end
        INPUT_STATE: begin
          if (bus.DATA_IN_ENABLE) begin
            acc        <= acc_next;
            data_out_r <= acc_next;
            k_en_r     <= 1'b1;
            j_en_r     <= last_k;
            i_en_r     <= last_j;
            if (last_all) begin
              ready_r <= 1'b1;
              state   <= STARTER_STATE;
            end
          end
        end
        ENDER_STATE: begin
          ready_r <= 1'b1;
          state   <= STARTER_STATE;
        end
        default: state <= STARTER_STATE;
      endcase
    end
  end

  assign bus.DATA_OUT          = data_out_r;
  assign bus.DATA_OUT_K_ENABLE = k_en_r;
  assign bus.DATA_OUT_J_ENABLE = j_en_r;
  assign bus.DATA_OUT_I_ENABLE = i_en_r;
  assign bus.READY             = ready_r;
endmodule
